id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline stage directly upstream of the ALU: buffers decoded instructions in a 2-entry skid FIFO.
//  Resolves RAW hazards by EX/MEM and MEM/WB forwarding and stalls on load-use. Presents opcode/a/b to alu.
//  Valid/ready handshake both sides; id_ready is registered (depends only on occupancy).
// PARAMETERS
//  XLEN    32  operand/result width (alu a, b, alu_out)
//  OPC_W   7   opcode width, {funct, type} exactly as driven onto alu.opcode
//  REG_AW  5   register index width; index 0 is hardwired zero
//  DEPTH   2   skid buffer entries (fixed at 2; other values unsupported)
// PORTS
//  clk         in   1       clock, all state updates on posedge
//  rst         in   1       synchronous, active-high reset
//  flush       in   1       branch redirect: kill all buffered and incoming instructions
//  id_valid    in   1       decode offers an instruction
//  id_ready    out  1       stage accepts (registered: occupancy < 2)
//  id_opcode   in   OPC_W   ALU opcode
//  id_pc       in   XLEN    instruction PC (passed through)
//  id_rs1      in   REG_AW  source 1 index
//  id_rs2      in   REG_AW  source 2 index
//  id_rs1_val  in   XLEN    regfile value for rs1
//  id_rs2_val  in   XLEN    regfile value for rs2
//  id_rd       in   REG_AW  destination index
//  id_wb_en    in   1       instruction writes rd
//  exm_wb_en   in   1       EX/MEM producer writes back
//  exm_is_load in   1       EX/MEM producer is a load (result not yet valid)
//  exm_rd      in   REG_AW  EX/MEM destination
//  exm_result  in   XLEN    EX/MEM result
//  mwb_wb_en   in   1       MEM/WB producer writes back
//  mwb_rd      in   REG_AW  MEM/WB destination
//  mwb_result  in   XLEN    MEM/WB final result
//  ex_valid    out  1       head entry issued to ALU
//  ex_ready    in   1       EX consumes head
//  ex_opcode   out  OPC_W   to alu.opcode
//  ex_a        out  XLEN    to alu.a (forwarded rs1)
//  ex_b        out  XLEN    to alu.b (forwarded rs2)
//  ex_rd/ex_wb_en/ex_pc out REG_AW/1/XLEN  head entry passthrough
// BEHAVIOUR
//  - Reset: entries invalid, count=0, ex_valid=0, id_ready=0 while rst=1; id_ready=1 the first cycle after.
//  - Push when id_valid&id_ready&~flush. Pop when ex_valid&ex_ready. Both in one cycle: count unchanged.
//  - id_ready(next) = (count_next < 2); push at count=2 impossible; count is 0..2, wraps never.
//  - Snoop: every cycle each valid entry with rsN==mwb_rd, mwb_wb_en, mwb_rd!=0 overwrites stored rsN_val.
//    Incoming entry pushed in the same cycle is also snooped before storage.
//  - Output forward, priority EX/MEM > MEM/WB > stored: match needs wb_en & rd==rs & rd!=0.
//  - rs==0 always yields 0 regardless of stored or forwarded values.
//  - Load-use: exm_is_load & exm_wb_en & exm_rd!=0 & exm_rd matches head rs1 or rs2 -> ex_valid=0 (hold).
//  - ex_valid = head valid & ~load_use & ~flush; outputs stable while ex_valid&~ex_ready.
//  - flush: synchronous; next cycle count=0, ex_valid=0, id_ready=1; same-cycle push discarded.
//  - Flush also gates the pop: in the flush cycle ex_valid=0. rst overrides flush.
//  - Latency: empty stage, push at cycle N -> ex_valid at N+1 (no load-use).
// STRUCTURE
//  - The pipe package holds OPC_W, XLEN and REG_AW constants, the existing `*_TYPE/funct opcode defines,
//    and the typedef id_ex_entry_t {opcode, pc, rs1, rs2, rs1_val, rs2_val, rd, wb_en}.
//  - One sub-module: fwd_mux (combinational forward/zero select per operand); instantiate twice.
// TESTING
//  - Reset with id_valid=1: ex_valid=0 and id_ready=0 during rst; id_ready=1 one cycle later.
//  - Push ADD rs1=1(val 5) rs2=2(val 7): next cycle ex_valid=1, ex_a=5, ex_b=7. Then ex_ready=0 three cycles:
//    outputs stable, third push stalls with id_ready=0.
//  - EX/MEM rd=1 result=100 and MEM/WB rd=1 result=200 in the same cycle: ex_a=100.
//  - rd=0 result=9 on both paths with rs1=0: ex_a=0.
//  - Load-use: exm_is_load=1, exm_rd=2, head rs2=2: ex_valid=0. Next cycle mwb_rd=2 result=42:
//    head updates, ex_valid=1, ex_b=42.
//  - Two entries buffered, flush=1 with id_valid=1: next cycle ex_valid=0, count=0, id_ready=1,
//    nothing issued for the discarded push.
//  - Random: random XLEN operands through the SUB/BLT opcodes; compare alu_out/alu_cc against the
//    golden model of unbuffered operands.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Purpose: shared constants, opcode encodings, entry payload and snoop helper
//          for the ID/EX stage.
package id_ex_stage_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned FUNCT_W = 4;
  localparam int unsigned TYPE_W  = 3;

  // Opcode = {funct, type}, exactly as driven onto alu.opcode
  localparam logic [TYPE_W-1:0]  ALU_TYPE  = 3'd0;
  localparam logic [TYPE_W-1:0]  BR_TYPE   = 3'd1;
  localparam logic [TYPE_W-1:0]  LD_TYPE   = 3'd2;
  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 4'd0;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 4'd1;
  localparam logic [FUNCT_W-1:0] FUNCT_BLT = 4'd4;
  localparam logic [OPC_W-1:0]   OPC_ADD   = {FUNCT_ADD, ALU_TYPE};
  localparam logic [OPC_W-1:0]   OPC_SUB   = {FUNCT_SUB, ALU_TYPE};
  localparam logic [OPC_W-1:0]   OPC_BLT   = {FUNCT_BLT, BR_TYPE};
  localparam logic [OPC_W-1:0]   OPC_LD    = {FUNCT_ADD, LD_TYPE};

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [REG_AW-1:0] rd;
    logic              wb_en;
  } id_ex_entry_t;

  // Refresh stored operands with the retiring MEM/WB result
  function automatic id_ex_entry_t snoop_entry(input id_ex_entry_t      e,
                                               input logic              wb_en,
                                               input logic [REG_AW-1:0] rd,
                                               input logic [XLEN-1:0]   res);
    id_ex_entry_t r;
    r = e;
    if (wb_en && (rd != '0) && (e.rs1 == rd)) r.rs1_val = res;
    if (wb_en && (rd != '0) && (e.rs2 == rd)) r.rs2_val = res;
    return r;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Purpose: decode-side, forwarding and EX-side signals of the ID/EX stage.
// master: environment (decode, EX/MEM, MEM/WB, ALU consumer); slave: the stage.
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;

  logic              id_valid;
  logic              id_ready;
  logic [OPC_W-1:0]  id_opcode;
  logic [XLEN-1:0]   id_pc;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [XLEN-1:0]   id_rs1_val;
  logic [XLEN-1:0]   id_rs2_val;
  logic [REG_AW-1:0] id_rd;
  logic              id_wb_en;

  logic              exm_wb_en;
  logic              exm_is_load;
  logic [REG_AW-1:0] exm_rd;
  logic [XLEN-1:0]   exm_result;
  logic              mwb_wb_en;
  logic [REG_AW-1:0] mwb_rd;
  logic [XLEN-1:0]   mwb_result;

  logic              ex_valid;
  logic              ex_ready;
  logic [OPC_W-1:0]  ex_opcode;
  logic [XLEN-1:0]   ex_a;
  logic [XLEN-1:0]   ex_b;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_wb_en;
  logic [XLEN-1:0]   ex_pc;

  modport master (
    output id_valid, id_opcode, id_pc, id_rs1, id_rs2, id_rs1_val, id_rs2_val,
           id_rd, id_wb_en, exm_wb_en, exm_is_load, exm_rd, exm_result,
           mwb_wb_en, mwb_rd, mwb_result, ex_ready,
    input  id_ready, ex_valid, ex_opcode, ex_a, ex_b, ex_rd, ex_wb_en, ex_pc
  );

  modport slave (
    input  id_valid, id_opcode, id_pc, id_rs1, id_rs2, id_rs1_val, id_rs2_val,
           id_rd, id_wb_en, exm_wb_en, exm_is_load, exm_rd, exm_result,
           mwb_wb_en, mwb_rd, mwb_result, ex_ready,
    output id_ready, ex_valid, ex_opcode, ex_a, ex_b, ex_rd, ex_wb_en, ex_pc
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Purpose: per-operand forward select, EX/MEM > MEM/WB > stored; x0 reads 0.
// Ports: rs_i source index, stored_i buffered value, exm_*/mwb_* producers,
//        val_c_o selected operand (combinational).
module id_ex_stage_fwd_mux
  import id_ex_stage_pkg::*;
(
  input  logic [REG_AW-1:0] rs_i,
  input  logic [XLEN-1:0]   stored_i,
  input  logic              exm_wb_en_i,
  input  logic [REG_AW-1:0] exm_rd_i,
  input  logic [XLEN-1:0]   exm_result_i,
  input  logic              mwb_wb_en_i,
  input  logic [REG_AW-1:0] mwb_rd_i,
  input  logic [XLEN-1:0]   mwb_result_i,
  output logic [XLEN-1:0]   val_c_o
);

  // rs_i != 0 in the forward branches also guarantees rd != 0
  always_comb begin
    val_c_o = stored_i;
    if (rs_i == '0)                                val_c_o = '0;
    else if (exm_wb_en_i && (exm_rd_i == rs_i))    val_c_o = exm_result_i;
    else if (mwb_wb_en_i && (mwb_rd_i == rs_i))    val_c_o = mwb_result_i;
  end

endmodule

// File: rtl/id_ex_stage.sv
// Purpose: ID/EX stage ahead of the ALU: 2-entry skid buffer with MEM/WB
//          snooping, EX/MEM and MEM/WB forwarding, and load-use hold.
// Ports: clk, rst (sync, active-high), flush (branch redirect),
//        pipe_if (slave): decode handshake, producer snoop, ALU handshake.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  id_ex_stage_if.slave pipe_if
);

  id_ex_entry_t     ent_q [DEPTH];
  id_ex_entry_t     ent_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             id_ready_q, id_ready_d;

  id_ex_entry_t     inc, head, s0, s1, si;
  logic             head_valid, load_use, ex_valid_c, push, pop;
  logic [XLEN-1:0]  a_fwd, b_fwd;

  // Incoming decode payload
  always_comb begin
    inc         = '0;
    inc.opcode  = pipe_if.id_opcode;
    inc.pc      = pipe_if.id_pc;
    inc.rs1     = pipe_if.id_rs1;
    inc.rs2     = pipe_if.id_rs2;
    inc.rs1_val = pipe_if.id_rs1_val;
    inc.rs2_val = pipe_if.id_rs2_val;
    inc.rd      = pipe_if.id_rd;
    inc.wb_en   = pipe_if.id_wb_en;
  end

  assign head       = ent_q[0];
  assign head_valid = (count_q != '0);

  // Load result not ready yet: hold the head until it reaches MEM/WB
  assign load_use = pipe_if.exm_is_load && pipe_if.exm_wb_en &&
                    (pipe_if.exm_rd != '0) &&
                    ((pipe_if.exm_rd == head.rs1) || (pipe_if.exm_rd == head.rs2));

  assign ex_valid_c = head_valid && !load_use && !flush;
  assign push       = pipe_if.id_valid && id_ready_q && !flush;
  assign pop        = ex_valid_c && pipe_if.ex_ready;

  id_ex_stage_fwd_mux u_fwd_a (
    .rs_i         (head.rs1),
    .stored_i     (head.rs1_val),
    .exm_wb_en_i  (pipe_if.exm_wb_en),
    .exm_rd_i     (pipe_if.exm_rd),
    .exm_result_i (pipe_if.exm_result),
    .mwb_wb_en_i  (pipe_if.mwb_wb_en),
    .mwb_rd_i     (pipe_if.mwb_rd),
    .mwb_result_i (pipe_if.mwb_result),
    .val_c_o      (a_fwd)
  );

  id_ex_stage_fwd_mux u_fwd_b (
    .rs_i         (head.rs2),
    .stored_i     (head.rs2_val),
    .exm_wb_en_i  (pipe_if.exm_wb_en),
    .exm_rd_i     (pipe_if.exm_rd),
    .exm_result_i (pipe_if.exm_result),
    .mwb_wb_en_i  (pipe_if.mwb_wb_en),
    .mwb_rd_i     (pipe_if.mwb_rd),
    .mwb_result_i (pipe_if.mwb_result),
    .val_c_o      (b_fwd)
  );

  // Buffer next state: slot 0 is always the head
  always_comb begin
    s0         = snoop_entry(ent_q[0], pipe_if.mwb_wb_en, pipe_if.mwb_rd, pipe_if.mwb_result);
    s1         = snoop_entry(ent_q[1], pipe_if.mwb_wb_en, pipe_if.mwb_rd, pipe_if.mwb_result);
    si         = snoop_entry(inc,      pipe_if.mwb_wb_en, pipe_if.mwb_rd, pipe_if.mwb_result);
    ent_d[0]   = s0;
    ent_d[1]   = s1;
    count_d    = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == '0) ent_d[0] = si;
        else               ent_d[1] = si;
        count_d = count_q + CNT_W'(1);
      end
      2'b01: begin
        ent_d[0] = s1;
        count_d  = count_q - CNT_W'(1);
      end
      // Push while popping only happens at count 1 (ready is low at 2)
      2'b11:   ent_d[0] = si;
      default: ;
    endcase
    if (flush) count_d = '0;
    id_ready_d = (count_d < CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q[0]   <= '0;
      ent_q[1]   <= '0;
      count_q    <= '0;
      id_ready_q <= 1'b0;
    end else begin
      ent_q[0]   <= ent_d[0];
      ent_q[1]   <= ent_d[1];
      count_q    <= count_d;
      id_ready_q <= id_ready_d;
    end
  end

  assign pipe_if.id_ready  = id_ready_q;
  assign pipe_if.ex_valid  = ex_valid_c;
  assign pipe_if.ex_opcode = head.opcode;
  assign pipe_if.ex_a      = a_fwd;
  assign pipe_if.ex_b      = b_fwd;
  assign pipe_if.ex_rd     = head.rd;
  assign pipe_if.ex_wb_en  = head.wb_en;
  assign pipe_if.ex_pc     = head.pc;

endmodule
